lvt_port_initiator: RTL
=======================

Name: lvt_port_initiator

Overview:
- Client-side initiator for one port of the multi-ported LVT memory.
- Accepts a valid/ready request stream (read or write) and drives the memory port signals (addr, en, d).
- Captures read data from the port's q after a fixed read latency and returns it through a valid/ready response FIFO.
- Credit counting guarantees the response FIFO never overflows. One instance sits in front of each memory port used by a client.

Parameters:
- WIDTH, 32: data width; must match the memory.
- DEPTH, 512: memory depth; address width is $clog2(DEPTH).
- RD_LATENCY, 1: cycles from the edge that samples mem_addr until mem_q is valid; must be ≥1.
- RSP_DEPTH, 4: response FIFO entries; also the maximum number of outstanding reads.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid & req_ready at a clk edge
- req_write  input  1  1 = write, 0 = read
- req_addr  input  $clog2(DEPTH)  request address
- req_data  input  WIDTH  write data; ignored for reads
- rsp_valid  output  1  read response available
- rsp_ready  input  1  consumer takes response
- rsp_data  output  WIDTH  read data, head of FIFO
- mem_addr  output  $clog2(DEPTH)  to memory port addr
- mem_en  output  1  to memory port en (write enable)
- mem_d  output  WIDTH  to memory port d
- mem_q  input  WIDTH  from memory port q
- outstanding  output  $clog2(RSP_DEPTH+1)  reads accepted but not yet popped

Behaviour:
- Reset (asynchronous, active-high; applies even mid-operation):
  - Outputs mem_addr=0, mem_d=0, mem_en=0, rsp_valid=0, outstanding=0.
  - FIFO pointers are cleared and the in-flight read shift register is cleared.
  - Reads in flight at reset never produce responses.
  - req_ready=0 while rst is high.
- Credit rule: req_ready = (outstanding < RSP_DEPTH). This applies to writes as well; writes also stall when credits are exhausted. req_ready does not depend on req_valid or req_write.
- Issue stage (registered): on acceptance at edge k:
  - mem_addr <= req_addr.
  - mem_d <= req_data for a write; unchanged for a read.
  - mem_en <= req_write.
  - rd_issue <= ~req_write.
  - With no acceptance at edge k: mem_en <= 0 and rd_issue <= 0; mem_addr and mem_d hold their values.
  - Throughput is one request per cycle while credits allow.
- Memory timing:
  - The memory samples the issued address/write at edge k+1.
  - For reads, mem_q is valid during the cycle after edge k+RD_LATENCY.
- In-flight tracking: shift register s[0..RD_LATENCY-1].
  - s[0] <= rd_issue; s[i] <= s[i-1].
  - When s[RD_LATENCY-1]=1, mem_q is pushed into the FIFO at the next edge, which is edge k+1+RD_LATENCY.
  - rsp_valid is visible in the following cycle. RD_LATENCY=1 gives a push at edge k+2.
- Response FIFO:
  - Depth RSP_DEPTH, circular, first-word-fall-through.
  - rsp_valid = (count != 0); rsp_data = entry at the head.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop is legal at any fill level, including full and empty. Push while count==RSP_DEPTH cannot occur because of credits.
  - Pointers wrap modulo RSP_DEPTH. RSP_DEPTH need not be a power of 2.
- outstanding counter:
  - +1 on acceptance of a read; -1 on pop.
  - Both in the same cycle: unchanged.
  - Writes never change it.
- Ordering:
  - Responses are returned strictly in read-acceptance order. Writes produce no response.
  - A read accepted the cycle after a write to the same address returns the new data, because the write is sampled one edge before the read.
- rsp_data while rsp_valid=0: don't-care. The bench must not check it.

Test Plan:
- Write 42 to addr 5, then read addr 5 → mem_en high for exactly one cycle with mem_addr=5 and mem_d=42. The read returns rsp_data=42 with rsp_valid rising RD_LATENCY+1 edges after the read-acceptance edge. outstanding goes 0→1→0 once popped.
- Write 10, 20, 30, 40 to addr 1..4, then four back-to-back reads with rsp_ready=1 → responses 10, 20, 30, 40 in order on consecutive cycles; req_ready stays 1 throughout.
- rsp_ready=0, six reads offered → req_ready drops after the 4th acceptance and outstanding=4. Raise rsp_ready: 4 responses drain, req_ready reasserts, and the remaining 2 complete in order.
- FIFO full with rsp_ready=1 while new reads are accepted every cycle → simultaneous push/pop. outstanding holds at its value, no data is lost or duplicated, and the pointers wrap correctly over ≥3 laps.
- Assert rst asynchronously (not on an edge) with 2 reads in flight and 1 in the FIFO → rsp_valid, mem_en and outstanding go to 0 immediately. No responses appear after release, and a following read of addr 5 returns the correct data.
- Write 7 to addr 9 followed next cycle by a read of addr 9 → rsp_data=7. Writes alone never assert rsp_valid.

Source files
------------

// File: rtl/lvt_port_initiator.sv
`default_nettype none
// ============================================================================
// Module   : lvt_port_initiator
// Function : valid/ready client front-end for one LVT memory port; read data
//            returns through a credit-protected first-word-fall-through FIFO.
// Revision : 1.0
// ============================================================================
module lvt_port_initiator #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 512,
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [$clog2(DEPTH)-1:0]       req_addr,
  input  logic [WIDTH-1:0]               req_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [WIDTH-1:0]               rsp_data,
  output logic [$clog2(DEPTH)-1:0]       mem_addr,
  output logic                           mem_en,
  output logic [WIDTH-1:0]               mem_d,
  input  logic [WIDTH-1:0]               mem_q,
  output logic [$clog2(RSP_DEPTH+1)-1:0] outstanding
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);
  localparam logic [OW-1:0] CREDITS  = OW'(RSP_DEPTH);

  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_d_q, mem_d_d;
  logic                  mem_en_q, mem_en_d;
  logic                  rd_issue_q, rd_issue_d;
  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         count_q, count_d;
  logic [OW-1:0]         out_q, out_d;
  logic [WIDTH-1:0]      fifo_mem [RSP_DEPTH];

  logic accept;
  logic rd_accept;
  logic push;
  logic pop;

  // Reads in flight are tracked by the shift register, so credits are
  // consumed at acceptance rather than when data lands in the FIFO.
  assign req_ready   = ~rst & (out_q < CREDITS);
  assign accept      = req_valid & req_ready;
  assign rd_accept   = accept & ~req_write;
  assign push        = inflight_q[RD_LATENCY-1];
  assign pop         = rsp_valid & rsp_ready;

  assign rsp_valid   = (count_q != '0);
  assign rsp_data    = fifo_mem[rd_ptr_q];
  assign mem_addr    = mem_addr_q;
  assign mem_en      = mem_en_q;
  assign mem_d       = mem_d_q;
  assign outstanding = out_q;

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    mem_en_d   = accept & req_write;
    rd_issue_d = rd_accept;
    if (accept) begin
      mem_addr_d = req_addr;
      if (req_write) begin
        mem_d_d = req_data;
      end
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_lat_one
      assign inflight_d = rd_issue_q;
    end else begin : g_lat_multi
      assign inflight_d = {inflight_q[RD_LATENCY-2:0], rd_issue_q};
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    case ({rd_accept, pop})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q <= '0;
      mem_d_q    <= '0;
      mem_en_q   <= 1'b0;
      rd_issue_q <= 1'b0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      mem_en_q   <= mem_en_d;
      rd_issue_q <= rd_issue_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_q;
    end
  end

endmodule
`default_nettype wire
